// File: rtl/board_io_pkg.sv
// board_io_pkg
// Shared types and helpers for the board output-side blocks (LED blinker,
// and later buzzer / seven-segment strobe logic).
//   blink_state_t : IDLE / ON / OFF states of a blink sequencer
//   timer_width() : width of a down-counter able to hold max(on, off)
package board_io_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } blink_state_t;

   // Width needed to hold the larger of the two phase lengths.
   function automatic int timer_width(input int on_cycles, input int off_cycles);
      int max_cycles;
      max_cycles = (on_cycles > off_cycles) ? on_cycles : off_cycles;
      return $clog2(max_cycles + 1);
   endfunction

endpackage

// File: rtl/blink_timer.sv
// blink_timer
// Loadable down-counter. A load takes priority over counting; while enabled
// the count decrements and then holds at zero.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (count -> 0)
//   load        : load load_value on the next rising edge
//   load_value  : value to load
//   enable      : decrement when non-zero
//   done        : high while the count is zero
module blink_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         enable,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/led_event_blinker.sv
// led_event_blinker
// Turns one-cycle event pulses into visible LED blinks, one blink per event.
// Events arriving mid-blink are queued in a saturating counter and replayed.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   event_pulse     : one blink request per cycle asserted
//   clear_overflow  : clears the sticky overflow flag (a same-cycle drop wins)
//   led             : registered LED drive, high = lit
//   busy            : high whenever a blink sequence is in progress
//   pending         : queued blinks not yet started
//   overflow        : sticky, set when an event is dropped at saturation
module led_event_blinker
   import board_io_pkg::*;
#(
   parameter int ON_CYCLES  = 2500000,
   parameter int OFF_CYCLES = 2500000,
   parameter int PEND_W     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              event_pulse,
   input  logic              clear_overflow,
   output logic              led,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
   localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0]     OFF_LOAD = TW'(OFF_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   blink_state_t  state;
   logic          timer_load;
   logic [TW-1:0] timer_value;
   logic          timer_done;
   logic          off_done;
   logic          pend_nz;
   logic          inc;
   logic          dec;
   logic          drop;

   blink_timer #(
      .W (TW)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (timer_load),
      .load_value (timer_value),
      .enable     (state != IDLE),
      .done       (timer_done)
   );

   always_comb begin
      off_done    = (state == OFF) && timer_done;
      pend_nz     = (pending != '0);
      timer_load  = 1'b0;
      timer_value = ON_LOAD;
      case (state)
         IDLE: if (event_pulse) begin
            timer_load  = 1'b1;
            timer_value = ON_LOAD;
         end
         ON: if (timer_done) begin
            timer_load  = 1'b1;
            timer_value = OFF_LOAD;
         end
         OFF: if (timer_done && (pend_nz || event_pulse)) begin
            timer_load  = 1'b1;
            timer_value = ON_LOAD;
         end
         default: ;
      endcase
      // An event at the end of OFF with nothing queued starts the next blink
      // itself and is never counted; with something queued it cancels the
      // consume, leaving pending unchanged.
      inc  = event_pulse && (state != IDLE) && !(off_done && !pend_nz);
      dec  = off_done && pend_nz;
      drop = inc && !dec && (pending == PEND_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         led      <= 1'b0;
         busy     <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: if (event_pulse) begin
               state <= ON;
               led   <= 1'b1;
               busy  <= 1'b1;
            end
            ON: if (timer_done) begin
               state <= OFF;
               led   <= 1'b0;
            end
            OFF: if (timer_done) begin
               if (pend_nz || event_pulse) begin
                  state <= ON;
                  led   <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               led   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase

         if (inc && !dec && !drop) begin
            pending <= pending + PEND_W'(1);
         end else if (dec && !inc) begin
            pending <= pending - PEND_W'(1);
         end

         if (drop) begin
            overflow <= 1'b1;
         end else if (clear_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_led_event_blinker.sv
// tb_led_event_blinker
// Directed bench for led_event_blinker with ON_CYCLES=3, OFF_CYCLES=2,
// PEND_W=2. Inputs are driven and outputs sampled on the falling edge.
// k counts rising edges since the first event of a scenario (k=0 is the
// edge that samples that event).
module tb_led_event_blinker;

   logic       clk;
   logic       rst_n;
   logic       event_pulse;
   logic       clear_overflow;
   logic       led;
   logic       busy;
   logic [1:0] pending;
   logic       overflow;

   int checks;
   int failures;

   led_event_blinker #(
      .ON_CYCLES  (3),
      .OFF_CYCLES (2),
      .PEND_W     (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .event_pulse    (event_pulse),
      .clear_overflow (clear_overflow),
      .led            (led),
      .busy           (busy),
      .pending        (pending),
      .overflow       (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present inputs for one rising edge, then return at the falling edge.
   task automatic tick_ev(input logic ev, input logic clr);
      event_pulse    = ev;
      clear_overflow = clr;
      @(posedge clk);
      @(negedge clk);
      event_pulse    = 1'b0;
      clear_overflow = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick_ev(1'b0, 1'b0);
      tick_ev(1'b0, 1'b0);
      rst_n = 1'b1;
      tick_ev(1'b0, 1'b0);
   endtask

   int rises;
   logic prev_led;
   logic [1:0] exp_pend;

   initial begin
      checks         = 0;
      failures       = 0;
      rst_n          = 1'b0;
      event_pulse    = 1'b0;
      clear_overflow = 1'b0;
      tick_ev(1'b0, 1'b0);
      tick_ev(1'b0, 1'b0);
      check("reset_led", led, 0);
      check("reset_busy", busy, 0);
      check("reset_pending", pending, 0);
      check("reset_overflow", overflow, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) tick_ev(1'b0, 1'b0);
      check("idle_led", led, 0);
      check("idle_busy", busy, 0);

      // Single event: led high k=0..2, low k=3..4, busy falls at k=5.
      for (int k = 0; k < 7; k++) begin
         tick_ev(k == 0, 1'b0);
         check($sformatf("single_led_k%0d", k), led, (k < 3) ? 1 : 0);
         check($sformatf("single_busy_k%0d", k), busy, (k < 5) ? 1 : 0);
         check($sformatf("single_pend_k%0d", k), pending, 0);
      end

      // Three consecutive events: blinks start at k=0,5,10; idle from k=15.
      apply_reset();
      for (int k = 0; k < 17; k++) begin
         tick_ev(k < 3, 1'b0);
         if (k == 0)      exp_pend = 2'd0;
         else if (k == 1) exp_pend = 2'd1;
         else if (k < 5)  exp_pend = 2'd2;
         else if (k < 10) exp_pend = 2'd1;
         else             exp_pend = 2'd0;
         check($sformatf("triple_led_k%0d", k), led, ((k < 15) && ((k % 5) < 3)) ? 1 : 0);
         check($sformatf("triple_busy_k%0d", k), busy, (k < 15) ? 1 : 0);
         check($sformatf("triple_pend_k%0d", k), pending, exp_pend);
      end

      // Saturation: start + 4 events, the fourth dropped; four blinks total.
      apply_reset();
      rises    = 0;
      prev_led = 1'b0;
      for (int k = 0; k < 22; k++) begin
         tick_ev(k < 5, 1'b0);
         if (led && !prev_led) rises++;
         prev_led = led;
         if (k < 4)       exp_pend = 2'(k);
         else if (k == 4) exp_pend = 2'd3;
         else if (k < 10) exp_pend = 2'd2;
         else if (k < 15) exp_pend = 2'd1;
         else             exp_pend = 2'd0;
         check($sformatf("sat_pend_k%0d", k), pending, exp_pend);
         check($sformatf("sat_ovf_k%0d", k), overflow, (k >= 4) ? 1 : 0);
      end
      check("sat_blinks", rises, 4);
      check("sat_busy_end", busy, 0);

      // Event on the final OFF cycle with pending=1.
      apply_reset();
      for (int k = 0; k < 16; k++) begin
         tick_ev((k == 0) || (k == 1) || (k == 5), 1'b0);
         if (k == 4) begin
            check("endoff_p1_led_k4", led, 0);
            check("endoff_p1_pend_k4", pending, 1);
         end
         if (k == 5) begin
            check("endoff_p1_led_k5", led, 1);
            check("endoff_p1_pend_k5", pending, 1);
         end
         if (k == 10) begin
            check("endoff_p1_led_k10", led, 1);
            check("endoff_p1_pend_k10", pending, 0);
         end
         if (k == 15) check("endoff_p1_busy_k15", busy, 0);
      end

      // Event on the final OFF cycle with pending=0: no idle gap.
      apply_reset();
      for (int k = 0; k < 11; k++) begin
         tick_ev((k == 0) || (k == 5), 1'b0);
         if ((k >= 3) && (k <= 5)) check($sformatf("endoff_p0_busy_k%0d", k), busy, 1);
         if (k == 5) begin
            check("endoff_p0_led_k5", led, 1);
            check("endoff_p0_pend_k5", pending, 0);
         end
         if (k == 10) check("endoff_p0_busy_k10", busy, 0);
      end

      // Asynchronous reset mid-ON with pending=2.
      apply_reset();
      for (int k = 0; k < 3; k++) tick_ev(1'b1, 1'b0);
      check("prereset_led", led, 1);
      check("prereset_pend", pending, 2);
      #2 rst_n = 1'b0;
      #1;
      check("async_led", led, 0);
      check("async_busy", busy, 0);
      check("async_pend", pending, 0);
      check("async_ovf", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick_ev(1'b0, 1'b0);
         check($sformatf("postreset_led_%0d", k), led, 0);
         check($sformatf("postreset_busy_%0d", k), busy, 0);
      end
      tick_ev(1'b1, 1'b0);
      check("postreset_new_led", led, 1);
      check("postreset_new_busy", busy, 1);

      // clear_overflow together with a drop: set wins; a later clear works.
      apply_reset();
      for (int k = 0; k < 6; k++) begin
         tick_ev(k < 5, (k == 4) || (k == 5));
         if (k == 3) check("clr_pend_k3", pending, 3);
         if (k == 4) begin
            check("clr_ovf_setwins", overflow, 1);
            check("clr_pend_k4", pending, 3);
         end
         if (k == 5) check("clr_ovf_cleared", overflow, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
